// File: rtl/morse_pkg.sv
// Shared constants and state encoding for the Morse transmitter stage.
// The optional repeat behaviour is selected with the MORSE_REPEAT_EN macro.
package morse_pkg;

  localparam int PAT_W     = 14;
  localparam int GAP_TICKS = 3;
  localparam int CNT_W     = $clog2(PAT_W + 1);
  localparam int GAP_W     = $clog2(GAP_TICKS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

endpackage

// File: rtl/morse_shifter_if.sv
// Handshake/status bundle between the controller/letter lookup and the Morse shifter.
interface morse_shifter_if;
  import morse_pkg::*;

  logic             start;
  logic [0:PAT_W-1] pattern;
  logic             tick;
  logic             abort;
  logic             led_out;
  logic             busy;
  logic             done;

  modport master (output start, pattern, tick, abort, input led_out, busy, done);
  modport slave  (input start, pattern, tick, abort, output led_out, busy, done);
endinterface

// File: rtl/morse_shift_reg.sv
// Symbol shift register: parallel load, shift toward bit 0 on enable, bit 0 exposed.
module morse_shift_reg
  import morse_pkg::*;
#(
  parameter int W = PAT_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_load,
  input  logic [0:W-1] i_load_val,
  input  logic         i_shift,
  output logic         o_bit0
);

  logic [0:W-1] r_sreg;

  // NOTE: a small datapath register like this is cheap to reset, so it is
  // cleared with everything else rather than left at X after power-up.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sreg <= '0;
    end else if (i_load) begin
      // NOTE: non-blocking so every register samples pre-edge values.
      r_sreg <= i_load_val;
    end else if (i_shift) begin
      r_sreg <= {r_sreg[1:W-1], 1'b0};
    end
  end

  assign o_bit0 = r_sreg[0];

endmodule

// File: rtl/morse_shifter.sv
// Serial Morse transmitter: latches a pattern on start and emits one symbol per tick.
// Define MORSE_REPEAT_EN to loop the pattern with a silent gap until abort.
module morse_shifter
  import morse_pkg::*;
(
  input logic            clk,
  input logic            reset_n,
  morse_shifter_if.slave bus
);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_led;
  logic             r_busy;
  logic             r_done;

  logic             w_load;
  logic             w_shift;
  logic             w_bit0;
  logic [0:PAT_W-1] w_load_val;

`ifdef MORSE_REPEAT_EN
  logic [0:PAT_W-1] r_held;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             w_gap_end;

  assign w_gap_end = (r_state == GAP) && bus.tick && (r_gap_cnt <= GAP_W'(1));
`endif

  // Shift-register controls must agree with the FSM decisions below.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latch).
    w_load     = 1'b0;
    w_shift    = 1'b0;
    w_load_val = bus.pattern;
    if (!bus.abort) begin
      if (r_state == IDLE && bus.start) w_load = 1'b1;
      if (bus.tick && (r_state == ALIGN || (r_state == SHIFT && r_cnt != '0)))
        w_shift = 1'b1;
`ifdef MORSE_REPEAT_EN
      if (w_gap_end) begin
        // The gap-ending tick emits held bit 0 directly, so load pre-shifted.
        w_load     = 1'b1;
        w_load_val = {r_held[1:PAT_W-1], 1'b0};
      end
`endif
    end
  end

  morse_shift_reg #(.W(PAT_W)) u_sreg (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_shift    (w_shift),
    .o_bit0     (w_bit0)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_led     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef MORSE_REPEAT_EN
      r_held    <= '0;
      r_gap_cnt <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      if (bus.abort) begin
        r_state   <= IDLE;
        r_cnt     <= '0;
        r_led     <= 1'b0;
        r_busy    <= 1'b0;
`ifdef MORSE_REPEAT_EN
        r_gap_cnt <= '0;
`endif
      end else begin
        case (r_state)
          IDLE: begin
            r_led <= 1'b0;
            if (bus.start) begin
              r_busy  <= 1'b1;
              r_cnt   <= CNT_W'(PAT_W);
              r_state <= ALIGN;
`ifdef MORSE_REPEAT_EN
              r_held  <= bus.pattern;
`endif
            end
          end
          ALIGN: begin
            if (bus.tick) begin
              r_led   <= w_bit0;
              r_cnt   <= r_cnt - 1'b1;
              r_state <= SHIFT;
            end
          end
          SHIFT: begin
            if (bus.tick) begin
              if (r_cnt != '0) begin
                r_led <= w_bit0;
                r_cnt <= r_cnt - 1'b1;
              end else begin
                r_led  <= 1'b0;
                r_done <= 1'b1;
`ifdef MORSE_REPEAT_EN
                r_gap_cnt <= GAP_W'(GAP_TICKS);
                r_state   <= GAP;
`else
                r_busy  <= 1'b0;
                r_state <= IDLE;
`endif
              end
            end
          end
`ifdef MORSE_REPEAT_EN
          GAP: begin
            if (bus.tick) begin
              if (!w_gap_end) begin
                r_gap_cnt <= r_gap_cnt - 1'b1;
              end else begin
                r_led     <= r_held[0];
                r_cnt     <= CNT_W'(PAT_W - 1);
                r_gap_cnt <= '0;
                r_state   <= SHIFT;
              end
            end
          end
`endif
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.led_out = r_led;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;

endmodule

// File: tb/tb_morse_shifter.sv
// Directed self-checking bench for morse_shifter; ticks arrive every 4 clock cycles.
module tb_morse_shifter;
  import morse_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [0:PAT_W-1] pat_s, pat_t, pat_y, pat_z;

  morse_shifter_if bus ();

  morse_shifter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One tick pulse; outputs sampled one clock after the tick edge.
  task automatic pulse_tick(output logic led, output logic dn, output logic bsy);
    @(negedge clk) bus.tick = 1'b1;
    @(negedge clk) bus.tick = 1'b0;
    led = bus.led_out;
    dn  = bus.done;
    bsy = bus.busy;
    repeat (2) @(negedge clk);
  endtask

  task automatic start_pattern(input logic [0:PAT_W-1] p);
    @(negedge clk);
    bus.pattern = p;
    bus.start   = 1'b1;
    @(negedge clk) bus.start = 1'b0;
  endtask

  task automatic test_reset;
    reset_n     = 1'b0;
    bus.start   = 1'b0;
    bus.tick    = 1'b0;
    bus.abort   = 1'b0;
    bus.pattern = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.led_out !== 1'b0) begin n_fail++; $display("FAIL reset_led: got %b want 0", bus.led_out); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_s;
    logic led, dn, bsy;
    start_pattern(pat_s);
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL s_busy_after_start: got %b want 1", bus.busy); end
    for (int i = 0; i < PAT_W; i++) begin
      pulse_tick(led, dn, bsy);
      n_checks++; if (led !== pat_s[i]) begin n_fail++; $display("FAIL s_led[%0d]: got %b want %b", i, led, pat_s[i]); end
      n_checks++; if (dn !== 1'b0 || bsy !== 1'b1) begin n_fail++; $display("FAIL s_status[%0d]: got done=%b busy=%b want done=0 busy=1", i, dn, bsy); end
    end
    pulse_tick(led, dn, bsy);
    n_checks++; if (dn !== 1'b1 || bsy !== 1'b0 || led !== 1'b0) begin n_fail++; $display("FAIL s_end: got done=%b busy=%b led=%b want 1 0 0", dn, bsy, led); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL s_done_width: got %b want 0", bus.done); end
    pulse_tick(led, dn, bsy);
    n_checks++; if (led !== 1'b0 || dn !== 1'b0 || bsy !== 1'b0) begin n_fail++; $display("FAIL s_idle_after: got led=%b done=%b busy=%b want 0 0 0", led, dn, bsy); end
  endtask

  task automatic test_start_with_tick;
    logic led, dn, bsy;
    @(negedge clk);
    bus.pattern = pat_t;
    bus.start   = 1'b1;
    bus.tick    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.tick  = 1'b0;
    n_checks++; if (bus.led_out !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL t_align: got led=%b busy=%b want 0 1", bus.led_out, bus.busy); end
    repeat (2) @(negedge clk);
    for (int i = 0; i < PAT_W; i++) begin
      pulse_tick(led, dn, bsy);
      n_checks++; if (led !== pat_t[i] || dn !== 1'b0) begin n_fail++; $display("FAIL t_led[%0d]: got led=%b done=%b want %b 0", i, led, dn, pat_t[i]); end
    end
    pulse_tick(led, dn, bsy);
    n_checks++; if (dn !== 1'b1 || bsy !== 1'b0) begin n_fail++; $display("FAIL t_end: got done=%b busy=%b want 1 0", dn, bsy); end
  endtask

  task automatic test_start_ignored;
    logic led, dn, bsy;
    start_pattern(pat_y);
    for (int i = 0; i < PAT_W; i++) begin
      if (i == 5) start_pattern(pat_s);
      pulse_tick(led, dn, bsy);
      n_checks++; if (led !== pat_y[i] || bsy !== 1'b1) begin n_fail++; $display("FAIL y_led[%0d]: got led=%b busy=%b want %b 1", i, led, bsy, pat_y[i]); end
    end
    pulse_tick(led, dn, bsy);
    n_checks++; if (dn !== 1'b1 || bsy !== 1'b0) begin n_fail++; $display("FAIL y_end: got done=%b busy=%b want 1 0", dn, bsy); end
  endtask

  task automatic test_abort;
    logic led, dn, bsy;
    start_pattern(pat_z);
    for (int i = 0; i < 6; i++) begin
      pulse_tick(led, dn, bsy);
      n_checks++; if (led !== pat_z[i]) begin n_fail++; $display("FAIL z_led[%0d]: got %b want %b", i, led, pat_z[i]); end
    end
    @(negedge clk);
    bus.tick  = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.tick  = 1'b0;
    bus.abort = 1'b0;
    n_checks++; if (bus.led_out !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL z_abort: got led=%b busy=%b done=%b want 0 0 0", bus.led_out, bus.busy, bus.done); end
    for (int i = 0; i < 9; i++) begin
      pulse_tick(led, dn, bsy);
      n_checks++; if (led !== 1'b0 || dn !== 1'b0 || bsy !== 1'b0) begin n_fail++; $display("FAIL z_after[%0d]: got led=%b done=%b busy=%b want 0 0 0", i, led, dn, bsy); end
    end
  endtask

  task automatic test_reset_mid_shift;
    logic led, dn, bsy;
    start_pattern(pat_s);
    for (int i = 0; i < 3; i++) pulse_tick(led, dn, bsy);
    n_checks++; if (led !== 1'b1) begin n_fail++; $display("FAIL rst_pre_led: got %b want 1", led); end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_checks++; if (bus.led_out !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_async: got led=%b busy=%b done=%b want 0 0 0", bus.led_out, bus.busy, bus.done); end
    @(negedge clk) reset_n = 1'b1;
    pulse_tick(led, dn, bsy);
    n_checks++; if (led !== 1'b0 || bsy !== 1'b0) begin n_fail++; $display("FAIL rst_idle: got led=%b busy=%b want 0 0", led, bsy); end
    start_pattern(pat_t);
    for (int i = 0; i < PAT_W; i++) begin
      pulse_tick(led, dn, bsy);
      n_checks++; if (led !== pat_t[i]) begin n_fail++; $display("FAIL rst_restart_led[%0d]: got %b want %b", i, led, pat_t[i]); end
    end
    pulse_tick(led, dn, bsy);
    n_checks++; if (dn !== 1'b1 || bsy !== 1'b0) begin n_fail++; $display("FAIL rst_restart_end: got done=%b busy=%b want 1 0", dn, bsy); end
  endtask

`ifdef MORSE_REPEAT_EN
  task automatic test_repeat;
    logic led, dn, bsy;
    start_pattern(pat_s);
    for (int i = 0; i < PAT_W; i++) begin
      pulse_tick(led, dn, bsy);
      n_checks++; if (led !== pat_s[i]) begin n_fail++; $display("FAIL rep_led[%0d]: got %b want %b", i, led, pat_s[i]); end
    end
    pulse_tick(led, dn, bsy);
    n_checks++; if (dn !== 1'b1 || bsy !== 1'b1 || led !== 1'b0) begin n_fail++; $display("FAIL rep_end: got done=%b busy=%b led=%b want 1 1 0", dn, bsy, led); end
    for (int i = 0; i < GAP_TICKS - 1; i++) begin
      pulse_tick(led, dn, bsy);
      n_checks++; if (led !== 1'b0 || dn !== 1'b0 || bsy !== 1'b1) begin n_fail++; $display("FAIL rep_gap[%0d]: got led=%b done=%b busy=%b want 0 0 1", i, led, dn, bsy); end
    end
    for (int i = 0; i < PAT_W; i++) begin
      pulse_tick(led, dn, bsy);
      n_checks++; if (led !== pat_s[i] || bsy !== 1'b1) begin n_fail++; $display("FAIL rep2_led[%0d]: got led=%b busy=%b want %b 1", i, led, bsy, pat_s[i]); end
    end
    pulse_tick(led, dn, bsy);
    n_checks++; if (dn !== 1'b1 || bsy !== 1'b1) begin n_fail++; $display("FAIL rep2_end: got done=%b busy=%b want 1 1", dn, bsy); end
    @(negedge clk) bus.abort = 1'b1;
    @(negedge clk) bus.abort = 1'b0;
    n_checks++; if (bus.busy !== 1'b0 || bus.led_out !== 1'b0) begin n_fail++; $display("FAIL rep_abort: got busy=%b led=%b want 0 0", bus.busy, bus.led_out); end
  endtask
`endif

  initial begin
    pat_s = 14'b10101000000000;
    pat_t = 14'b11100000000000;
    pat_y = 14'b11101011101110;
    pat_z = 14'b11101110101000;
    test_reset;
`ifdef MORSE_REPEAT_EN
    test_repeat;
    test_abort;
`else
    test_single_s;
    test_start_with_tick;
    test_start_ignored;
    test_abort;
    test_reset_mid_shift;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
